// File: rtl/seg_to_binary_capture.sv
// -----------------------------------------------------------------------------
// seg_to_binary_capture
//
// Captures a three-digit 7-segment display that is scanned one digit at a time
// and turns the displayed decimal number into an unsigned 8-bit value.
//
// A frame starts with the first valid digit sample. It completes once the ones,
// tens and hundreds positions have all been seen, in any order. The decimal
// value is then range-checked. Values 0..255 are published on Value with a
// one-cycle Valid pulse. Any abort produces a one-cycle Error pulse. A frame is
// aborted by an out-of-range value, an undecodable segment pattern, or a frame
// that does not complete within TIMEOUT cycles.
//
// Ports:
//   Clock          in   1  sole clock, rising edge
//   Resetn         in   1  asynchronous active-low reset
//   A..G           in   1  segment lines of the selected digit, active-low
//   Dig            in   3  one-hot digit select: [0]=ones [1]=tens [2]=hundreds
//   Value          out  8  last published binary value
//   Valid          out  1  one-cycle pulse when Value is updated
//   Error          out  1  one-cycle pulse when a frame is aborted
//
// Parameter:
//   TIMEOUT  maximum number of cycles from the first capture to frame completion
//
// Optional feature (macro SEG_CAPTURE_CONFIRM_EN):
//   When the macro is defined, a value is published only when two consecutive
//   in-range frames agree. A frame that does not match the previous one is
//   kept as the candidate, and nothing is published for it.
// -----------------------------------------------------------------------------
module seg_to_binary_capture #(
    parameter int TIMEOUT = 1000
) (
    input  logic       Clock,
    input  logic       Resetn,
    input  logic       A,
    input  logic       B,
    input  logic       C,
    input  logic       D,
    input  logic       E,
    input  logic       F,
    input  logic       G,
    input  logic [2:0] Dig,
    output logic [7:0] Value,
    output logic       Valid,
    output logic       Error
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        CHECK   = 2'd2,
        PUBLISH = 2'd3
    } state_t;

    // Returns {valid, digit}; valid is 0 for any pattern that is not 0..9.
    function automatic logic [4:0] seg_decode(input logic [6:0] seg);
        logic [4:0] dec;
        case (seg)
            7'b0000001: dec = {1'b1, 4'd0};
            7'b1001111: dec = {1'b1, 4'd1};
            7'b0010010: dec = {1'b1, 4'd2};
            7'b0000110: dec = {1'b1, 4'd3};
            7'b1001100: dec = {1'b1, 4'd4};
            7'b0100100: dec = {1'b1, 4'd5};
            7'b0100000: dec = {1'b1, 4'd6};
            7'b0001111: dec = {1'b1, 4'd7};
            7'b0000000: dec = {1'b1, 4'd8};
            7'b0001100: dec = {1'b1, 4'd9};
            default:    dec = {1'b0, 4'd0};
        endcase
        return dec;
    endfunction

    state_t        r_state;
    state_t        w_state_nxt;
    logic [3:0]    r_one;
    logic [3:0]    r_ten;
    logic [3:0]    r_hun;
    logic [2:0]    r_mask;
    logic [CW-1:0] r_cnt;
    logic [7:0]    r_value;
    logic          r_valid;
    logic          r_error;

    logic [6:0]    w_seg;
    logic [4:0]    w_dec;
    logic          w_onehot;
    logic          w_sample_ok;
    logic          w_sample_bad;
    logic          w_accept;
    logic [2:0]    w_mask_cap;
    logic          w_timeout;
    logic [9:0]    w_sum;
    logic          w_in_range;
    logic          w_frame_ok;
    logic          w_publish;
    logic [7:0]    w_value_nxt;
    logic          w_valid_nxt;
    logic          w_error_nxt;

`ifdef SEG_CAPTURE_CONFIRM_EN
    logic [7:0]    r_cand;
    logic          r_cand_vld;
`endif

    assign w_seg    = {A, B, C, D, E, F, G};
    assign w_dec    = seg_decode(w_seg);
    assign w_onehot = (Dig == 3'b001) || (Dig == 3'b010) || (Dig == 3'b100);

    // Samples with zero or several Dig bits set are ignored entirely.
    assign w_sample_ok  = w_onehot && w_dec[4];
    assign w_sample_bad = w_onehot && !w_dec[4];

    // Digits are only taken while a frame can still be assembled.
    assign w_accept   = w_sample_ok && ((r_state == IDLE) || (r_state == COLLECT));
    assign w_mask_cap = w_accept ? (r_mask | Dig) : r_mask;

    // A sample that completes the mask on the last allowed cycle still counts.
    assign w_timeout = (r_state == COLLECT) && (r_cnt == CNT_LAST) && (w_mask_cap != 3'b111);

    assign w_sum      = (10'(r_hun) * 10'd100) + (10'(r_ten) * 10'd10) + 10'(r_one);
    assign w_in_range = (w_sum <= 10'd255);

    // A completed in-range frame leaves CHECK; an invalid sample takes precedence.
    assign w_frame_ok = (r_state == CHECK) && !w_sample_bad && w_in_range;

`ifdef SEG_CAPTURE_CONFIRM_EN
    assign w_publish = w_frame_ok && r_cand_vld && (r_cand == w_sum[7:0]);
`else
    assign w_publish = w_frame_ok;
`endif

    // State register.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_sample_ok) begin
                    w_state_nxt = COLLECT;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            COLLECT: begin
                if (w_sample_bad) begin
                    w_state_nxt = IDLE;
                end else if (r_mask == 3'b111) begin
                    w_state_nxt = CHECK;
                end else if (w_timeout) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_state_nxt = COLLECT;
                end
            end
            CHECK: begin
                if (w_frame_ok) begin
                    w_state_nxt = PUBLISH;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            PUBLISH: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Output logic: next values of the registered Value/Valid/Error.
    // Valid is registered on the CHECK->PUBLISH edge, two edges after the mask completes.
    always_comb begin
        w_value_nxt = r_value;
        w_valid_nxt = 1'b0;
        w_error_nxt = 1'b0;
        if (w_sample_bad || w_timeout) begin
            w_error_nxt = 1'b1;
        end else if ((r_state == CHECK) && !w_in_range) begin
            w_error_nxt = 1'b1;
        end else if (w_publish) begin
            w_value_nxt = w_sum[7:0];
            w_valid_nxt = 1'b1;
        end else begin
            w_error_nxt = 1'b0;
        end
    end

    // Output registers.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            r_value <= 8'd0;
            r_valid <= 1'b0;
            r_error <= 1'b0;
        end else begin
            r_value <= w_value_nxt;
            r_valid <= w_valid_nxt;
            r_error <= w_error_nxt;
        end
    end

    // Digit registers, captured mask and frame timeout counter.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            r_one  <= 4'd0;
            r_ten  <= 4'd0;
            r_hun  <= 4'd0;
            r_mask <= 3'b000;
            r_cnt  <= '0;
        end else begin
            if (w_accept) begin
                case (Dig)
                    3'b001:  r_one <= w_dec[3:0];
                    3'b010:  r_ten <= w_dec[3:0];
                    3'b100:  r_hun <= w_dec[3:0];
                    default: r_one <= r_one;
                endcase
            end
            // Every return to IDLE (publish, abort, timeout) discards the mask.
            if (w_state_nxt == IDLE) begin
                r_mask <= 3'b000;
            end else begin
                r_mask <= w_mask_cap;
            end
            // Counter starts at 0 on the first capture and advances while collecting.
            if ((r_state == COLLECT) && (w_state_nxt == COLLECT)) begin
                r_cnt <= r_cnt + CW'(1);
            end else begin
                r_cnt <= '0;
            end
        end
    end

`ifdef SEG_CAPTURE_CONFIRM_EN
    // Candidate holds the sum of the most recent completed in-range frame.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            r_cand     <= 8'd0;
            r_cand_vld <= 1'b0;
        end else if (w_frame_ok) begin
            r_cand     <= w_sum[7:0];
            r_cand_vld <= 1'b1;
        end else begin
            r_cand     <= r_cand;
            r_cand_vld <= r_cand_vld;
        end
    end
`endif

    assign Value = r_value;
    assign Valid = r_valid;
    assign Error = r_error;

endmodule

// File: doc/seg_to_binary_capture.md
SEG_TO_BINARY_CAPTURE -- requirements
Module: seg_to_binary_capture

Interface
REQ-001 Parameter TIMEOUT, default 1000, SHALL be the maximum number of clock cycles from the first digit capture to frame completion.
REQ-002 Clock  input  1  SHALL be the sole clock; all state SHALL update on its rising edge.
REQ-003 Resetn  input  1  SHALL be the asynchronous, active-low reset.
REQ-004 A,B,C,D,E,F,G  input  1 each  SHALL be the segment lines of one 7-segment digit, active-low (0 = lit).
REQ-005 Dig  input  3  SHALL select the digit on A..G, one-hot active-high: bit0 = ones, bit1 = tens, bit2 = hundreds.
REQ-006 Value  output  8  SHALL be the last successfully published unsigned binary value.
REQ-007 Valid  output  1  SHALL pulse high for one cycle when Value is updated.
REQ-008 Error  output  1  SHALL pulse high for one cycle when a frame is aborted.

Function
REQ-009 Segment patterns {A..G} SHALL decode as follows: 0 = 0000001, 1 = 1001111, 2 = 0010010, 3 = 0000110, 4 = 1001100, 5 = 0100100, 6 = 0100000, 7 = 0001111, 8 = 0000000, 9 = 0001100; every other pattern SHALL be invalid.
REQ-010 A sample SHALL be taken on each rising edge where Dig has exactly one bit set; Dig = 000 or Dig with more than one bit set SHALL be ignored with no state change.
REQ-011 A valid sample SHALL load the digit register for the selected position and set its bit in a 3-bit captured mask.
REQ-012 Recapturing a position already in the mask SHALL overwrite that digit; the mask SHALL be unchanged.
REQ-013 FSM states SHALL be IDLE, COLLECT, CHECK and PUBLISH; the FSM SHALL reset to IDLE.
REQ-014 In IDLE, the first valid sample SHALL move the FSM to COLLECT and start the timeout counter at 0.
REQ-015 In COLLECT, when the mask reaches 111, the FSM SHALL go to CHECK on the next edge; digits MAY arrive in any order.
REQ-016 CHECK SHALL compute sum = H*100 + T*10 + O at 10-bit width.
REQ-017 If sum <= 255, CHECK SHALL go to PUBLISH; PUBLISH SHALL register Value = sum[7:0] and Valid = 1.
REQ-018 Valid SHALL be asserted exactly 2 cycles after the edge that completes the mask.
REQ-019 If sum > 255 (for example 256-999), CHECK SHALL assert Error, leave Value unchanged, and return to IDLE.
REQ-020 An invalid segment pattern with exactly one Dig bit set SHALL assert Error, clear the mask, and return the FSM to IDLE, in any state.
REQ-021 In COLLECT, if the timeout counter reaches TIMEOUT-1 with the mask not equal to 111, the block SHALL assert Error, clear the mask, and return to IDLE.
REQ-022 Samples arriving during CHECK or PUBLISH SHALL be ignored; PUBLISH SHALL return to IDLE with the mask cleared.
REQ-023 If an invalid pattern and a timeout occur in the same cycle, Error SHALL pulse exactly once.
REQ-024 Valid and Error SHALL never be high in the same cycle.

Reset
REQ-025 Asserting Resetn low SHALL immediately force Value = 0, Valid = 0, Error = 0, mask = 000, digit registers = 0, timeout counter = 0, and FSM = IDLE, including mid-frame.
REQ-026 The first sample SHALL be accepted on the first rising edge after Resetn deasserts.

Configuration
REQ-027 With macro SEG_CAPTURE_CONFIRM_EN defined, PUBLISH SHALL update Value and pulse Valid only when sum equals the sum of the previous completed in-range frame; otherwise it SHALL store sum as the candidate, return to IDLE silently, and leave Value unchanged.
REQ-028 With SEG_CAPTURE_CONFIRM_EN undefined, every in-range frame SHALL publish per REQ-017, and no candidate register SHALL exist.

Verification
REQ-029 Ones = 0100100 (5), tens = 1001100 (4), hundreds = 1001111 (1) in consecutive cycles -> Value = 145 and Valid pulses 2 cycles after the hundreds edge (macro undefined).
REQ-030 Digits 2, 5, 5 then 2, 5, 6 (H, T, O) -> first frame publishes 255, second frame gives Error and Value stays 255.
REQ-031 Tens = 1111111 with Dig = 010 mid-frame -> Error pulse, mask cleared, next full frame 0, 0, 7 -> Value = 7.
REQ-032 TIMEOUT = 8, only ones captured, then idle -> Error 8 cycles after the capture, FSM returns to IDLE.
REQ-033 Resetn pulsed low after two digits captured -> all outputs 0 immediately, then a full frame 0, 4, 2 -> Value = 42.
REQ-034 Macro defined, frames 1, 2, 3 then 1, 2, 3 -> Valid only after the second frame with Value = 123; frames 1, 2, 3 then 1, 2, 4 -> no Valid.
